// File: rtl/muldiv_pkg.sv
// Package: muldiv_pkg
// Purpose: shared types and operation-decode helpers for the RV32M
//          multiply/divide unit (rv_muldiv_unit and rv_muldiv_step).
// Contents:
//   md_op_e     - funct3 encoding of the eight M-extension operations
//   md_state_e  - control FSM states
//   is_div      - operation belongs to the divide/remainder group
//   is_signed_a - rs1 is interpreted as two's complement
//   is_signed_b - rs2 is interpreted as two's complement
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP,
        S_DONE
    } md_state_e;

    function automatic logic is_div(md_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    // MUL is treated as unsigned: the low half of the product does not
    // depend on operand signedness.
    function automatic logic is_signed_a(md_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(md_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/rv_muldiv_step.sv
// Module: rv_muldiv_step
// Purpose: one radix-2 step of the shared iterative datapath, purely
//          combinational. The {hi, lo} register pair is reused by both
//          operation groups:
//            multiply: hi = partial product, lo = multiplier (consumed LSB
//                      first, low product bits shift in from the top)
//            divide:   hi = partial remainder, lo = dividend (consumed MSB
//                      first, quotient bits shift in from the bottom)
// Ports:
//   is_div  in  1     select trial-subtract (1) or add-or-skip (0)
//   hi_i    in  XLEN  upper half of the working pair
//   lo_i    in  XLEN  lower half of the working pair
//   m_i     in  XLEN  multiplicand / divisor magnitude
//   hi_o    out XLEN  updated upper half
//   lo_o    out XLEN  updated lower half
module rv_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] m_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem_in;
    logic          fits;

    // Add-or-skip keeps the carry so the right shift does not lose it.
    assign sum    = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : '0);
    // Restoring division: remainder shifted left with the next dividend bit.
    assign rem_in = {hi_i, lo_i[XLEN-1]};
    assign fits   = rem_in >= {1'b0, m_i};

    always_comb begin
        // NOTE: every output gets a value on every path through an always_comb
        // block; a path that leaves one unassigned infers a latch.
        hi_o = sum[XLEN:1];
        lo_o = {sum[0], lo_i[XLEN-1:1]};
        if (is_div) begin
            // The difference is smaller than the divisor, so XLEN bits hold it.
            hi_o = fits ? XLEN'(rem_in - {1'b0, m_i}) : rem_in[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], fits};
        end
    end

endmodule

// File: rtl/rv_muldiv_unit.sv
// Module: rv_muldiv_unit
// Purpose: iterative RV32M multiply/divide unit with a valid/ready request
//          and response handshake. Operands are converted to magnitudes on
//          acceptance, processed unsigned for XLEN/BITS_PER_CYCLE cycles,
//          then given their sign in a single FIXUP cycle. Division by zero,
//          signed overflow and zero multiply operands bypass the iteration.
// Ports:
//   clk          in   1      rising-edge clock
//   reset_n      in   1      asynchronous active-low reset
//   flush        in   1      synchronous abort of any in-flight operation
//   req_valid    in   1      request present
//   req_ready    out  1      unit is idle and can accept
//   req_op       in   3      funct3 of the M-extension operation
//   req_rs1      in   XLEN   operand A / dividend
//   req_rs2      in   XLEN   operand B / divisor
//   req_tag      in   TAG_W  opaque tag echoed on resp_tag
//   resp_valid   out  1      result valid, held until resp_ready
//   resp_ready   in   1      consumer accepts result
//   resp_result  out  XLEN   result
//   resp_tag     out  TAG_W  tag of the returned result
//   busy         out  1      unit not idle
module rv_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_W          = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_result,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    md_state_e        state_q, state_d;
    md_op_e           op_q;
    logic             neg_q;
    logic [XLEN-1:0]  hi_q, lo_q, m_q, result_q;
    logic [TAG_W-1:0] tag_q;
    logic [CNT_W-1:0] count_q;

    // Request decode
    md_op_e          op_in;
    logic            sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            special;
    logic [XLEN-1:0] special_res;

    assign op_in  = md_op_e'(req_op);
    assign sign_a = is_signed_a(op_in) && req_rs1[XLEN-1];
    assign sign_b = is_signed_b(op_in) && req_rs2[XLEN-1];
    assign mag_a  = sign_a ? -req_rs1 : req_rs1;
    assign mag_b  = sign_b ? -req_rs2 : req_rs2;

    always_comb begin
        special     = 1'b0;
        special_res = '0;
        if (is_div(op_in)) begin
            if (req_rs2 == '0) begin
                special     = 1'b1;
                special_res = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : req_rs1;
            end else if ((op_in inside {OP_DIV, OP_REM}) &&
                         req_rs1 == {1'b1, {(XLEN-1){1'b0}}} && req_rs2 == '1) begin
                special     = 1'b1;
                special_res = (op_in == OP_DIV) ? req_rs1 : '0;
            end
        end else if (req_rs1 == '0 || req_rs2 == '0) begin
            special = 1'b1;
        end
    end

    // Iteration datapath: BITS_PER_CYCLE steps chained per clock
    logic            op_is_div;
    logic [XLEN-1:0] hi_c [BITS_PER_CYCLE+1];
    logic [XLEN-1:0] lo_c [BITS_PER_CYCLE+1];

    assign op_is_div = is_div(op_q);
    assign hi_c[0]   = hi_q;
    assign lo_c[0]   = lo_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        rv_muldiv_step #(.XLEN(XLEN)) u_step (
            .is_div (op_is_div),
            .hi_i   (hi_c[i]),
            .lo_i   (lo_c[i]),
            .m_i    (m_q),
            .hi_o   (hi_c[i+1]),
            .lo_o   (lo_c[i+1])
        );
    end

    // Sign fixup: neg_q already encodes which result is negative for this op
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_result;

    assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};

    always_comb begin
        case (op_q)
            OP_MUL:                       fix_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_result = neg_q ? -lo_q : lo_q;
            default:                      fix_result = neg_q ? -hi_q : hi_q;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process ordering.
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (req_valid) state_d = special ? S_DONE : S_CALC;
                S_CALC:  if (count_q == CNT_W'(N - 1)) state_d = S_FIXUP;
                S_FIXUP: state_d = S_DONE;
                S_DONE:  if (resp_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM: outputs (req_ready depends on state only, never on req_valid)
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        resp_valid = (state_q == S_DONE);
    end

    assign resp_result = result_q;
    assign resp_tag    = tag_q;

    // Datapath registers. result_q/tag_q only change in IDLE and FIXUP, so
    // they stay stable while a response is waiting in DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            result_q <= '0;
            tag_q    <= '0;
            count_q  <= '0;
        end else if (!flush) begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    op_q    <= op_in;
                    tag_q   <= req_tag;
                    count_q <= '0;
                    hi_q    <= '0;
                    // Remainder follows the dividend; everything else is
                    // negative exactly when the operand signs differ.
                    neg_q   <= (op_in inside {OP_REM, OP_REMU}) ? sign_a : (sign_a ^ sign_b);
                    if (is_div(op_in)) begin
                        lo_q <= mag_a;
                        m_q  <= mag_b;
                    end else begin
                        lo_q <= mag_b;
                        m_q  <= mag_a;
                    end
                    if (special) result_q <= special_res;
                end
                S_CALC: begin
                    hi_q    <= hi_c[BITS_PER_CYCLE];
                    lo_q    <= lo_c[BITS_PER_CYCLE];
                    count_q <= count_q + CNT_W'(1);
                end
                S_FIXUP: result_q <= fix_result;
                default: ;
            endcase
        end
    end

endmodule
